// File: rtl/dfpu_pkg.sv
// rtl/dfpu_pkg.sv - shared decimal FPU constants and the single-digit BCD add rule
package dfpu_pkg;

  localparam int BCD_DIGIT_W = 4;

  // Returns {carry_out, sum_digit}. Any 4-bit operand value is accepted; out-of-range
  // digits are not flagged and simply follow the same correct-by-10 rule.
  function automatic logic [BCD_DIGIT_W:0] bcd_digit_add(
    input logic [BCD_DIGIT_W-1:0] a,
    input logic [BCD_DIGIT_W-1:0] b,
    input logic                   ci
  );
    logic [BCD_DIGIT_W:0] s;
    logic [BCD_DIGIT_W:0] r;
    s = {1'b0, a} + {1'b0, b} + {{BCD_DIGIT_W{1'b0}}, ci};
    if (s >= 5'd10) begin
      r = {1'b1, 4'(s - 5'd10)};
    end else begin
      r = {1'b0, s[BCD_DIGIT_W-1:0]};
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_add_cell.sv
// rtl/bcd_digit_add_cell.sv - combinational one-digit BCD adder cell
module bcd_digit_add_cell
  import dfpu_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] a,
  input  logic [BCD_DIGIT_W-1:0] b,
  input  logic                   ci,
  output logic [BCD_DIGIT_W-1:0] s,
  output logic                   co
);

  assign {co, s} = bcd_digit_add(a, b, ci);

endmodule

// File: rtl/bcd_add.sv
// rtl/bcd_add.sv - registered packed-BCD adder slice with ripple decimal carry
module bcd_add
  import dfpu_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ci,
  input  logic [BCD_DIGIT_W*DIGITS-1:0]   a,
  input  logic [BCD_DIGIT_W*DIGITS-1:0]   b,
  output logic [BCD_DIGIT_W*DIGITS-1:0]   o,
  output logic                            c
);

  localparam int W = BCD_DIGIT_W * DIGITS;

  logic [DIGITS:0] carry;
  logic [W-1:0]    sum;

  assign carry[0] = ci;

  // Carry ripples from digit 0 upward; parents chain c into the next slice's ci.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_add_cell u_cell (
      .a  (a[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .b  (b[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .ci (carry[g]),
      .s  (sum[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .co (carry[g+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o <= '0;
      c <= 1'b0;
    end else begin
      o <= sum;
      c <= carry[DIGITS];
    end
  end

endmodule

// File: tb/tb_bcd_add.sv
// tb/tb_bcd_add.sv - self-checking bench for bcd_add against a decimal reference model
module tb_bcd_add;

  localparam int DIGITS = 2;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ci  = 1'b0;
  logic [W-1:0] a   = '0;
  logic [W-1:0] b   = '0;
  logic [W-1:0] o;
  logic         c;

  int total = 0;
  int bad   = 0;

  bcd_add #(.DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .ci  (ci),
    .a   (a),
    .b   (b),
    .o   (o),
    .c   (c)
  );

  always #5 clk = ~clk;

  function automatic int bcd_to_int(input logic [W-1:0] v);
    int r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int_to_bcd(input int v);
    logic [W-1:0] r = '0;
    int t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Valid-BCD reference: plain decimal arithmetic, split into o and c.
  function automatic logic [W:0] dec_ref(input logic [W-1:0] x, input logic [W-1:0] y, input logic cin);
    int total_v = bcd_to_int(x) + bcd_to_int(y) + int'(cin);
    int modulus = 1;
    for (int i = 0; i < DIGITS; i++) modulus = modulus * 10;
    return {total_v >= modulus, int_to_bcd(total_v % modulus)};
  endfunction

  // Arbitrary-digit reference following the stated per-digit rule with integers.
  function automatic logic [W:0] rule_ref(input logic [W-1:0] x, input logic [W-1:0] y, input logic cin);
    logic [W-1:0] r = '0;
    int carry = int'(cin);
    for (int i = 0; i < DIGITS; i++) begin
      int s = int'(x[i*4 +: 4]) + int'(y[i*4 +: 4]) + carry;
      carry = (s >= 10) ? 1 : 0;
      if (s >= 10) s = s - 10;
      r[i*4 +: 4] = 4'(s % 16);
    end
    return {carry != 0, r};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; a = 8'h45; b = 8'h38; ci = 1'b1;
    step();
    total++;
    if ({c, o} !== 9'h000) begin
      bad++;
      $display("FAIL reset: got c=%0b o=%h, want c=0 o=00", c, o);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [6] = '{8'h45, 8'h99, 8'h99, 8'h50, 8'h00, 8'h19};
    logic [W-1:0] tb [6] = '{8'h38, 8'h99, 8'h00, 8'h50, 8'h00, 8'h81};
    logic         tc [6] = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0};
    logic [W:0]   te [6] = '{9'h083, 9'h199, 9'h100, 9'h100, 9'h000, 9'h100};
    for (int i = 0; i < 6; i++) begin
      a = ta[i]; b = tb[i]; ci = tc[i];
      step();
      total++;
      if ({c, o} !== te[i]) begin
        bad++;
        $display("FAIL directed %h+%h+%0b: got c=%0b o=%h, want c=%0b o=%h",
                 ta[i], tb[i], tc[i], c, o, te[i][W], te[i][W-1:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ta [3] = '{8'h01, 8'h09, 8'h12};
    logic [W-1:0] tb [3] = '{8'h01, 8'h01, 8'h34};
    logic [W:0]   te [3] = '{9'h002, 9'h010, 9'h046};
    ci = 1'b0;
    a = ta[0]; b = tb[0];
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({c, o} !== te[i]) begin
        bad++;
        $display("FAIL back_to_back[%0d]: got c=%0b o=%h, want c=%0b o=%h",
                 i, c, o, te[i][W], te[i][W-1:0]);
      end
      if (i < 2) begin
        a = ta[i+1]; b = tb[i+1];
      end
    end
  endtask

  task automatic test_reset_midstream();
    a = 8'h77; b = 8'h22; ci = 1'b0; rst = 1'b1;
    step();
    total++;
    if ({c, o} !== 9'h000) begin
      bad++;
      $display("FAIL reset_midstream hold: got c=%0b o=%h, want c=0 o=00", c, o);
    end
    rst = 1'b0;
    step();
    total++;
    if ({c, o} !== 9'h099) begin
      bad++;
      $display("FAIL reset_midstream release: got c=%0b o=%h, want c=0 o=99", c, o);
    end
  endtask

  task automatic test_non_bcd();
    logic [W:0] exp;
    a = 8'hAA; b = 8'h00; ci = 1'b0;
    step();
    total++;
    if ({c, o} !== 9'h110) begin
      bad++;
      $display("FAIL non_bcd AA+00: got c=%0b o=%h, want c=1 o=10", c, o);
    end
    for (int i = 0; i < 300; i++) begin
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(0, 255));
      ci = 1'($urandom_range(0, 1));
      exp = rule_ref(a, b, ci);
      step();
      total++;
      if ({c, o} !== exp) begin
        bad++;
        $display("FAIL non_bcd_rand %h+%h+%0b: got c=%0b o=%h, want c=%0b o=%h",
                 a, b, ci, c, o, exp[W], exp[W-1:0]);
      end
    end
  endtask

  // Pipelined random valid-BCD stream: a new vector every cycle, expectation queued.
  task automatic test_random_stream();
    logic [W:0] q[$];
    logic [W:0] exp;
    for (int i = 0; i <= 200; i++) begin
      if (i > 0) begin
        step();
        exp = q.pop_front();
        total++;
        if ({c, o} !== exp) begin
          bad++;
          $display("FAIL stream[%0d]: got c=%0b o=%h, want c=%0b o=%h",
                   i, c, o, exp[W], exp[W-1:0]);
        end
      end
      if (i < 200) begin
        a = int_to_bcd(int'($urandom_range(0, 99)));
        b = int_to_bcd(int'($urandom_range(0, 99)));
        ci = 1'($urandom_range(0, 1));
        q.push_back(dec_ref(a, b, ci));
      end
    end
  endtask

  task automatic test_exhaustive();
    logic [W:0] exp;
    int errs = 0;
    for (int x = 0; x < 100; x++) begin
      for (int y = 0; y < 100; y++) begin
        for (int k = 0; k < 2; k++) begin
          a = int_to_bcd(x); b = int_to_bcd(y); ci = 1'(k);
          exp = dec_ref(a, b, ci);
          step();
          total++;
          if ({c, o} !== exp) begin
            bad++;
            errs++;
            if (errs <= 10)
              $display("FAIL exhaustive %h+%h+%0d: got c=%0b o=%h, want c=%0b o=%h",
                       a, b, k, c, o, exp[W], exp[W-1:0]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midstream();
    test_non_bcd();
    test_random_stream();
    test_exhaustive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
